// File: rtl/meas_pkg.sv
// Shared encodings for the multi-channel frequency/period meter.
package meas_pkg;
    typedef enum logic {
        MODE_FREQ   = 1'b0,
        MODE_PERIOD = 1'b1
    } mode_e;

    typedef enum logic {
        ST_WAIT_EDGE = 1'b0,
        ST_RUN       = 1'b1
    } ch_state_e;
endpackage

// File: rtl/freq_meter_ch.sv
// One meter channel: synchroniser, edge detector, edge counter, period FSM
// and the published result/overflow registers.
module freq_meter_ch
    import meas_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             boundary,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync_q;
    logic             prev_q, edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic             cnt_ovf_q, cnt_ovf_d, cnt_ovf_nx;
    logic [CNT_W-1:0] per_q, per_d, per_nx;
    logic [CNT_W-1:0] last_q, last_d, last_nx;
    logic             done_q, done_d, done_nx;
    logic [CNT_W-1:0] meas_q, meas_d, res;
    logic             ovf_q, ovf_d, res_ovf;
    ch_state_e        state_q, state_d;

    // Synchroniser and prev keep running while disabled so a held-high input
    // does not fake an edge when en returns.
    assign edge_d = en & sync_q[1] & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            edge_q    <= 1'b0;
            state_q   <= ST_WAIT_EDGE;
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
            per_q     <= '0;
            last_q    <= '0;
            done_q    <= 1'b0;
            meas_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], sig_in};
            prev_q    <= sync_q[1];
            edge_q    <= edge_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_ovf_q <= cnt_ovf_d;
            per_q     <= per_d;
            last_q    <= last_d;
            done_q    <= done_d;
            meas_q    <= meas_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en || clr) begin
            state_d = ST_WAIT_EDGE;
        end else begin
            case (state_q)
                ST_WAIT_EDGE: if (edge_q) state_d = ST_RUN;
                ST_RUN:       state_d = ST_RUN;
                default:      state_d = ST_WAIT_EDGE;
            endcase
        end
    end

    always_comb begin
        cnt_nx     = (edge_q && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        cnt_ovf_nx = cnt_ovf_q | (edge_q & (cnt_q == CNT_MAX));
        per_nx     = per_q;
        last_nx    = last_q;
        done_nx    = done_q;
        case (state_q)
            ST_WAIT_EDGE: if (edge_q) per_nx = CNT_W'(1);
            ST_RUN: begin
                if (edge_q) begin
                    last_nx = per_q;
                    done_nx = 1'b1;
                    per_nx  = CNT_W'(1);
                end else if (per_q != CNT_MAX) begin
                    per_nx = per_q + CNT_W'(1);
                end
            end
            default: per_nx = '0;
        endcase

        // Results include this cycle's edge so a boundary edge closes with its window.
        if (mode == MODE_PERIOD) begin
            res     = done_nx ? last_nx : CNT_MAX;
            res_ovf = !done_nx || (last_nx == CNT_MAX);
        end else begin
            res     = cnt_nx;
            res_ovf = cnt_ovf_nx;
        end

        meas_d    = boundary ? res : meas_q;
        ovf_d     = boundary ? res_ovf : ovf_q;
        cnt_d     = boundary ? '0 : cnt_nx;
        cnt_ovf_d = boundary ? 1'b0 : cnt_ovf_nx;
        done_d    = boundary ? 1'b0 : done_nx;
        per_d     = per_nx;
        last_d    = last_nx;
        if (!en || clr) begin
            cnt_d     = '0;
            cnt_ovf_d = 1'b0;
            per_d     = '0;
            last_d    = '0;
            done_d    = 1'b0;
        end
    end

    assign meas = meas_q;
    assign ovf  = ovf_q;
endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel frequency/period meter: gate timer, mode sampling, enable
// handling and the update pulse around an array of channel instances.
module freq_meter_mc
    import meas_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int CNT_W       = 14,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int GATE_W      = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       sig_in,
    output logic [CHANNELS*CNT_W-1:0] meas,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      meas_valid
);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0] timer_q, timer_d;
    logic              mode_q, mode_d;
    logic              armed_q;
    logic              valid_q;
    logic              boundary, mode_chg;

    assign boundary = en && (timer_q == GATE_LAST);
    assign mode_chg = boundary && (mode != mode_q);

    // armed_q loads mode on the first cycle out of reset, so mode_q tracks the
    // mode present at reset without an async load of a data input.
    always_comb begin
        timer_d = timer_q + GATE_W'(1);
        if (!en || boundary) timer_d = '0;
        mode_d = (!armed_q || boundary) ? mode : mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            mode_q  <= MODE_FREQ;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            mode_q  <= mode_d;
            armed_q <= 1'b1;
            valid_q <= boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        freq_meter_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (mode_chg),
            .mode     (mode_q),
            .boundary (boundary),
            .sig_in   (sig_in[i]),
            .meas     (meas[i*CNT_W +: CNT_W]),
            .ovf      (ovf[i])
        );
    end

    assign meas_valid = valid_q;
endmodule

// File: tb/tb_freq_meter_mc.sv
// Scoreboard bench for freq_meter_mc with a 100-cycle gate; an 8-bit and a
// 4-bit instance share the same stimulus.
module tb_freq_meter_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sig_in;
    logic [23:0] meas;
    logic [2:0]  ovf;
    logic        meas_valid;
    logic [11:0] meas4;
    logic [2:0]  ovf4;
    logic        valid4;

    int          per_cfg[3] = '{0, 0, 0};
    int          ph[3] = '{0, 0, 0};
    logic [2:0]  hold_v = 3'b000;

    typedef struct packed {
        logic [23:0] m;
        logic [2:0]  o;
    } exp_t;
    exp_t        sb[$];
    logic [4:0]  sb4[$];
    exp_t        e, last_e;
    logic [4:0]  e4;
    int          checks = 0;
    int          errors = 0;
    int          n;
    bit          to;

    freq_meter_mc #(.CHANNELS(3), .CNT_W(8), .GATE_CYCLES(100), .GATE_W(7)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sig_in(sig_in),
        .meas(meas), .ovf(ovf), .meas_valid(meas_valid)
    );

    freq_meter_mc #(.CHANNELS(3), .CNT_W(4), .GATE_CYCLES(100), .GATE_W(7)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sig_in(sig_in),
        .meas(meas4), .ovf(ovf4), .meas_valid(valid4)
    );

    always #5 clk = ~clk;

    // Square waves with whole-cycle period per channel; period 0 holds a level.
    initial begin
        sig_in = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (per_cfg[i] == 0) begin
                    sig_in[i] = hold_v[i];
                end else begin
                    ph[i] = (ph[i] + 1) % per_cfg[i];
                    sig_in[i] = (ph[i] < per_cfg[i] / 2);
                end
            end
        end
    end

    task automatic wait_valid(output int cyc, output bit tmo);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (meas_valid !== 1'b1 && cyc < 300);
        tmo = (meas_valid !== 1'b1);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL valid_timeout: no meas_valid within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        per_cfg = '{10, 4, 0}; hold_v = 3'b000;
        repeat (3) @(negedge clk);
        checks++; if (meas !== 24'h0) begin errors++; $display("FAIL rst_meas: got %h exp 0", meas); end
        checks++; if (ovf !== 3'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 000", ovf); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", meas_valid); end
        rst = 1'b0;
        wait_valid(n, to);
        checks++; if (n != 100) begin errors++; $display("FAIL rst_latency: got %0d exp 100", n); end
    endtask

    task automatic test_freq();
        for (int w = 0; w < 3; w++) begin
            sb.push_back('{m: {8'd0, 8'd25, 8'd10}, o: 3'b000});
            wait_valid(n, to);
            e = sb.pop_front();
            checks++; if (meas !== e.m) begin errors++; $display("FAIL freq_meas: got %h exp %h", meas, e.m); end
            checks++; if (ovf !== e.o) begin errors++; $display("FAIL freq_ovf: got %b exp %b", ovf, e.o); end
            checks++; if (((w == 0) ? n : n + 1) != 100) begin errors++; $display("FAIL freq_spacing: got %0d exp 100", (w == 0) ? n : n + 1); end
            @(negedge clk);
            checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b exp 0", meas_valid); end
        end
    endtask

    task automatic test_saturation();
        per_cfg[0] = 4;
        wait_valid(n, to);
        sb4.push_back({1'b1, 4'd15});
        wait_valid(n, to);
        e4 = sb4.pop_front();
        checks++; if (meas4[3:0] !== e4[3:0]) begin errors++; $display("FAIL sat_meas: got %0d exp %0d", meas4[3:0], e4[3:0]); end
        checks++; if (ovf4[0] !== e4[4]) begin errors++; $display("FAIL sat_ovf: got %b exp %b", ovf4[0], e4[4]); end
        checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b exp 1", valid4); end
        per_cfg[0] = 10;
        wait_valid(n, to);
        sb4.push_back({1'b0, 4'd10});
        wait_valid(n, to);
        e4 = sb4.pop_front();
        checks++; if (meas4[3:0] !== e4[3:0]) begin errors++; $display("FAIL unsat_meas: got %0d exp %0d", meas4[3:0], e4[3:0]); end
        checks++; if (ovf4[0] !== e4[4]) begin errors++; $display("FAIL unsat_ovf: got %b exp %b", ovf4[0], e4[4]); end
    endtask

    task automatic test_mode_switch();
        repeat (40) @(negedge clk);
        mode = 1'b1;
        sb.push_back('{m: {8'd0, 8'd25, 8'd10}, o: 3'b000});
        wait_valid(n, to);
        checks++; if (n != 60) begin errors++; $display("FAIL mode_latency: got %0d exp 60", n); end
        e = sb.pop_front();
        checks++; if (meas !== e.m) begin errors++; $display("FAIL mode_old_meas: got %h exp %h", meas, e.m); end
        checks++; if (ovf !== e.o) begin errors++; $display("FAIL mode_old_ovf: got %b exp %b", ovf, e.o); end
        sb.push_back('{m: {8'd255, 8'd4, 8'd10}, o: 3'b100});
        wait_valid(n, to);
        e = sb.pop_front();
        checks++; if (meas !== e.m) begin errors++; $display("FAIL mode_new_meas: got %h exp %h", meas, e.m); end
        checks++; if (ovf !== e.o) begin errors++; $display("FAIL mode_new_ovf: got %b exp %b", ovf, e.o); end
    endtask

    task automatic test_period();
        per_cfg[1] = 37; hold_v[2] = 1'b1;
        wait_valid(n, to);
        for (int w = 0; w < 2; w++) begin
            sb.push_back('{m: {8'd255, 8'd37, 8'd10}, o: 3'b100});
            wait_valid(n, to);
            e = sb.pop_front();
            last_e = e;
            checks++; if (meas !== e.m) begin errors++; $display("FAIL period_meas: got %h exp %h", meas, e.m); end
            checks++; if (ovf !== e.o) begin errors++; $display("FAIL period_ovf: got %b exp %b", ovf, e.o); end
        end
    endtask

    task automatic test_enable();
        int seen = 0;
        repeat (30) @(negedge clk);
        en = 1'b0;
        repeat (37) begin
            @(negedge clk);
            if (meas_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL en_low_valid: got %0d pulses exp 0", seen); end
        checks++; if (meas !== last_e.m) begin errors++; $display("FAIL en_hold_meas: got %h exp %h", meas, last_e.m); end
        checks++; if (ovf !== last_e.o) begin errors++; $display("FAIL en_hold_ovf: got %b exp %b", ovf, last_e.o); end
        en = 1'b1;
        sb.push_back('{m: {8'd255, 8'd37, 8'd10}, o: 3'b100});
        wait_valid(n, to);
        checks++; if (n != 100) begin errors++; $display("FAIL en_latency: got %0d exp 100", n); end
        e = sb.pop_front();
        checks++; if (meas !== e.m) begin errors++; $display("FAIL en_meas: got %h exp %h", meas, e.m); end
        checks++; if (ovf !== e.o) begin errors++; $display("FAIL en_ovf: got %b exp %b", ovf, e.o); end
    endtask

    task automatic test_reset_mid();
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (meas !== 24'h0) begin errors++; $display("FAIL async_rst_meas: got %h exp 0", meas); end
        checks++; if (ovf !== 3'b0) begin errors++; $display("FAIL async_rst_ovf: got %b exp 000", ovf); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b exp 0", meas_valid); end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{m: {8'd255, 8'd37, 8'd10}, o: 3'b100});
        wait_valid(n, to);
        checks++; if (n != 100) begin errors++; $display("FAIL rst_mid_latency: got %0d exp 100", n); end
        e = sb.pop_front();
        checks++; if (meas !== e.m) begin errors++; $display("FAIL rst_mid_meas: got %h exp %h", meas, e.m); end
        checks++; if (ovf !== e.o) begin errors++; $display("FAIL rst_mid_ovf: got %b exp %b", ovf, e.o); end
    endtask

    initial begin
        test_reset();
        test_freq();
        test_saturation();
        test_mode_switch();
        test_period();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_meter_mc.md
# freq_meter_mc

Multi-channel, parametrised frequency/period meter and the successor to the single-channel 14-bit frequency counter in the DDS test path. Each channel takes an asynchronous 1-bit signal, such as a DDS output MSB or an LFSR noise bit. At the end of every gate window the block publishes, for all channels at once, one of two results selected by mode:
- the rising-edge count, or
- the most recent period in clock cycles.

Results saturate and carry an overflow flag. A one-cycle valid pulse marks each update.

## Interface
- `CHANNELS`, 3, number of independent input channels
- `CNT_W`, 14, result width per channel
- `GATE_CYCLES`, 50_000_000, gate window length in `clk` cycles (1 s at 50 MHz)
- `GATE_W`, 26, gate timer width, must hold `GATE_CYCLES-1`

Ports:
- `clk`  in  1  system clock. This is the block's one clock.
- `rst`  in  1  reset, asynchronous and active-high
- `en`  in  1  measurement enable
- `mode`  in  1  0 = frequency (edge count per window), 1 = period (clk cycles between rising edges)
- `sig_in`  in  `CHANNELS`  asynchronous inputs, one bit per channel
- `meas`  out  `CHANNELS*CNT_W`  results; channel i at `[i*CNT_W +: CNT_W]`
- `ovf`  out  `CHANNELS`  per-channel saturation flag for the published window
- `meas_valid`  out  1  one-cycle pulse; `meas` and `ovf` updated in the same cycle

## Operation
- **Input conditioning (per channel):** 2-FF synchroniser, then a registered rising-edge detector. An edge is flagged 3 cycles after the input rises.
- **Gate timer:**
  - Counts 0..`GATE_CYCLES-1`, then wraps.
  - The cycle with the timer at `GATE_CYCLES-1` is the boundary.
  - `mode` is sampled into `mode_q` only at a boundary or at reset. A changed `mode_q` clears all channel state.
- **Frequency mode:**
  - The edge counter increments on each flagged edge and stops at `2^CNT_W-1` (sticky overflow for the window).
  - At the boundary the count is latched into `meas`, including any edge flagged in the boundary cycle.
  - The counter and overflow then restart from 0.
- **Period mode, per-channel FSM:**
  - WAIT_EDGE: on a flagged edge, move to RUN with period counter = 1.
  - RUN: counter increments each cycle and saturates at `2^CNT_W-1`. On a flagged edge, the counter value is stored as the last period, the counter restarts at 1, and the FSM stays in RUN.
  - At the boundary, `meas` is set to the last period completed in this window.
  - If no period completed in the window, `meas` = all-ones and `ovf` = 1. A saturated period also sets `ovf` = 1.
  - The "completed" mark clears at each boundary. The FSM state persists across boundaries.
- **Enable:**
  - `en` = 0 clears the gate timer, all counters, the FSMs (to WAIT_EDGE) and the pending flags.
  - While `en` = 0, no `meas_valid` is produced and `meas`/`ovf` hold their last values.
- **Reset (`rst`), including mid-window:**
  - `meas` = 0, `ovf` = 0, `meas_valid` = 0.
  - Timer = 0, FSMs in WAIT_EDGE, `mode_q` = `mode`.

## Timing
- `meas_valid` is high the cycle after the boundary and lasts exactly 1 cycle. `meas` and `ovf` change only in that cycle.
- First `meas_valid` comes `GATE_CYCLES` cycles after reset release or after `en` rises, i.e. one full window.
- Consecutive pulses are exactly `GATE_CYCLES` cycles apart.
- Edge and boundary in the same cycle: the edge belongs to the window that is closing.
- `mode` change: takes effect for the window that starts after the next boundary.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `meas_pkg`:
  - mode encodings `MODE_FREQ` = 0 and `MODE_PERIOD` = 1
  - FSM state encodings `ST_WAIT_EDGE` and `ST_RUN`
- Sub-module `freq_meter_ch` contains one channel: synchroniser, edge detector, edge counter, period FSM/counter, and result/overflow registers.
- It is instantiated with a generate loop over `CHANNELS`.
- The top level holds the gate timer, `mode_q`, the `en` handling and `meas_valid`.

## Test plan
Use `GATE_CYCLES` = 100 and `CNT_W` = 8 unless stated.

1. **Frequency mode:** ch0 square with period 10, ch1 period 4, ch2 held at 0.
   - Every valid after the first: `meas` = {0, 25, 10}, `ovf` = 0.
   - Pulses exactly 100 cycles apart.
2. **Saturation:** `CNT_W` = 4, ch0 period 4.
   - ch0 `meas` = 15, `ovf[0]` = 1.
   - After ch0 is slowed to period 10: next window gives `meas` = 10, `ovf[0]` = 0.
3. **Period mode:** ch0 period 10, ch1 period 37, ch2 held at 1.
   - `meas` = {255, 37, 10}, `ovf` = 3'b100.
4. **Mode switch:** raise `mode` at timer = 40.
   - The next valid is still a frequency result.
   - The following valid is a period result (ch0 = 10).
5. **Enable:** drop `en` for 37 cycles mid-window.
   - No `meas_valid` during the low period; `meas`/`ovf` hold.
   - First valid comes 100 cycles after `en` rises.
6. **Reset mid-window:** assert `rst` at timer = 60 with non-zero results.
   - `meas`/`ovf`/`meas_valid` go to 0 immediately (asynchronously).
   - First valid comes 100 cycles after release.
